// File: rtl/arm_reg_file.sv
// ARM-style register bank: NREGS registers, three combinational read ports and one write port.
// The top index is the PC, which has its own branch-load and auto-increment path.
module arm_reg_file #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NREGS     = 16,
  parameter int unsigned AW        = 4,
  parameter int unsigned PC_INC    = 4,
  parameter int unsigned PC_RD_OFS = 8,
  parameter int unsigned BYPASS    = 1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             WE_N,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  input  logic [AW-1:0]    RA_A,
  input  logic [AW-1:0]    RA_B,
  input  logic [AW-1:0]    RA_C,
  output logic [WIDTH-1:0] RD_A,
  output logic [WIDTH-1:0] RD_B,
  output logic [WIDTH-1:0] RD_C,
  input  logic             PC_LD_N,
  input  logic [WIDTH-1:0] PC_D,
  input  logic             PC_INC_N,
  output logic [WIDTH-1:0] PC_Q
);

  localparam int unsigned PcIdx = NREGS - 1;

  logic [WIDTH-1:0] regs_q [NREGS-1];
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pc_rd;
  logic             gen_we;
  logic             pc_we;
  logic [AW-1:0]    ra [3];
  logic [WIDTH-1:0] rd [3];

  // Codes above the PC index fall outside this range and are dropped.
  assign gen_we = !WE_N && (WA < AW'(PcIdx));
  assign pc_we  = !WE_N && (WA == AW'(PcIdx));
  assign pc_rd  = pc_q + WIDTH'(PC_RD_OFS);

  always_comb begin
    pc_d = pc_q;
    if (pc_we) begin
      pc_d = WD;
    end else if (!PC_LD_N) begin
      pc_d = PC_D;
    end else if (!PC_INC_N) begin
      pc_d = pc_q + WIDTH'(PC_INC);
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int unsigned i = 0; i < NREGS - 1; i++) begin
        regs_q[i] <= '0;
      end
      pc_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NREGS - 1; i++) begin
        if (gen_we && (WA == AW'(i))) begin
          regs_q[i] <= WD;
        end
      end
      pc_q <= pc_d;
    end
  end

  assign ra[0] = RA_A;
  assign ra[1] = RA_B;
  assign ra[2] = RA_C;

  // PC reads show the prefetch view and are never forwarded from the write port.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd[p] = '0;
      if (ra[p] == AW'(PcIdx)) begin
        rd[p] = pc_rd;
      end else begin
        for (int unsigned i = 0; i < NREGS - 1; i++) begin
          if (ra[p] == AW'(i)) begin
            rd[p] = regs_q[i];
          end
        end
        if ((BYPASS != 0) && gen_we && (WA == ra[p])) begin
          rd[p] = WD;
        end
      end
    end
  end

  assign RD_A = rd[0];
  assign RD_B = rd[1];
  assign RD_C = rd[2];
  assign PC_Q = pc_q;

endmodule

// File: tb/tb_arm_reg_file.sv
// Bench for arm_reg_file: bypassing and non-bypassing instances on shared stimulus, checked
// every cycle against an array model plus directed literal checks.
module tb_arm_reg_file;

  logic        CLK = 1'b0;
  logic        CLR;
  logic        WE_N, PC_LD_N, PC_INC_N;
  logic [3:0]  WA, RA_A, RA_B, RA_C;
  logic [31:0] WD, PC_D;
  logic [31:0] rd_a_b, rd_b_b, rd_c_b, pc_q_b;
  logic [31:0] rd_a_n, rd_b_n, rd_c_n, pc_q_n;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_reg [16];
  logic [31:0] m_pc;

  always #5 CLK = ~CLK;

  arm_reg_file #(.BYPASS(1)) dut_b (
    .CLK(CLK), .CLR(CLR), .WE_N(WE_N), .WA(WA), .WD(WD),
    .RA_A(RA_A), .RA_B(RA_B), .RA_C(RA_C),
    .RD_A(rd_a_b), .RD_B(rd_b_b), .RD_C(rd_c_b),
    .PC_LD_N(PC_LD_N), .PC_D(PC_D), .PC_INC_N(PC_INC_N), .PC_Q(pc_q_b)
  );

  arm_reg_file #(.BYPASS(0)) dut_n (
    .CLK(CLK), .CLR(CLR), .WE_N(WE_N), .WA(WA), .WD(WD),
    .RA_A(RA_A), .RA_B(RA_B), .RA_C(RA_C),
    .RD_A(rd_a_n), .RD_B(rd_b_n), .RD_C(rd_c_n),
    .PC_LD_N(PC_LD_N), .PC_D(PC_D), .PC_INC_N(PC_INC_N), .PC_Q(pc_q_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: architectural state as a plain array, updated from the rules directly.
  always @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < 16; i++) m_reg[i] <= 32'h0;
      m_pc <= 32'h0;
    end else begin
      if (!WE_N && WA != 4'd15) m_reg[WA] <= WD;
      if (!WE_N && WA == 4'd15)  m_pc <= WD;
      else if (!PC_LD_N)         m_pc <= PC_D;
      else if (!PC_INC_N)        m_pc <= m_pc + 32'd4;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [3:0] ra, input bit byp);
    if (ra == 4'd15) return m_pc + 32'd8;
    if (byp && !WE_N && WA == ra) return WD;
    return m_reg[ra];
  endfunction

  // Per-cycle comparison on the falling edge, away from the update edge.
  always @(negedge CLK) begin
    chk("pc_q_byp",  pc_q_b, m_pc);
    chk("pc_q_nbyp", pc_q_n, m_pc);
    chk("rd_a_byp",  rd_a_b, exp_rd(RA_A, 1'b1));
    chk("rd_b_byp",  rd_b_b, exp_rd(RA_B, 1'b1));
    chk("rd_c_byp",  rd_c_b, exp_rd(RA_C, 1'b1));
    chk("rd_a_nbyp", rd_a_n, exp_rd(RA_A, 1'b0));
    chk("rd_b_nbyp", rd_b_n, exp_rd(RA_B, 1'b0));
    chk("rd_c_nbyp", rd_c_n, exp_rd(RA_C, 1'b0));
  end

  task automatic idle();
    WE_N = 1'b1; PC_LD_N = 1'b1; PC_INC_N = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    CLR = 1'b0;
    idle();
    WA = 4'd0; WD = 32'h0; PC_D = 32'h0;
    RA_A = 4'd0; RA_B = 4'd15; RA_C = 4'd1;
    #12;
    chk("reset_pc_q", pc_q_b, 32'h0);
    chk("reset_pc_read", rd_b_b, 32'h8);
    CLR = 1'b1;
    step();

    // Forwarding versus registered view of a general write.
    WE_N = 1'b0; WA = 4'd3; WD = 32'hDEADBEEF; RA_A = 4'd3;
    #1;
    chk("bypass_same_cycle", rd_a_b, 32'hDEADBEEF);
    chk("nobypass_old_value", rd_a_n, 32'h0);
    step();
    idle();
    #1;
    chk("bypass_after_edge", rd_a_b, 32'hDEADBEEF);
    chk("nobypass_after_edge", rd_a_n, 32'hDEADBEEF);

    // Auto-increment from reset and prefetch view.
    PC_INC_N = 1'b0;
    step(); chk("pc_inc1", pc_q_b, 32'h4);
    step(); chk("pc_inc2", pc_q_b, 32'h8);
    step(); chk("pc_inc3", pc_q_b, 32'hC);
    idle(); RA_B = 4'd15;
    #1;
    chk("pc_read_ofs", rd_b_b, 32'h14);

    // Wrap of the increment.
    PC_LD_N = 1'b0; PC_D = 32'hFFFFFFFC;
    step();
    PC_LD_N = 1'b1; PC_INC_N = 1'b0;
    step();
    chk("pc_wrap", pc_q_n, 32'h0);

    // Priority: write port beats load beats increment; PC reads never forwarded.
    PC_LD_N = 1'b0; PC_D = 32'h100; PC_INC_N = 1'b0;
    WE_N = 1'b0; WA = 4'd15; WD = 32'h200; RA_C = 4'd15;
    #1;
    chk("pc_read_no_bypass", rd_c_b, 32'h8);
    step();
    chk("pc_prio_write", pc_q_b, 32'h200);
    WE_N = 1'b1;
    step();
    chk("pc_prio_load", pc_q_b, 32'h100);

    // General write alongside increment.
    idle();
    WE_N = 1'b0; WA = 4'd5; WD = 32'h55; PC_INC_N = 1'b0;
    step();
    idle(); RA_A = 4'd5;
    #1;
    chk("pc_with_write", pc_q_b, 32'h104);
    chk("r5_with_inc", rd_a_n, 32'h55);

    // Same register on all ports; disabled write leaves it alone.
    WE_N = 1'b0; WA = 4'd7; WD = 32'h1234;
    step();
    WE_N = 1'b1; WD = 32'hFFFF; RA_A = 4'd7; RA_B = 4'd7; RA_C = 4'd7;
    step();
    chk("r7_port_a", rd_a_b, 32'h1234);
    chk("r7_port_b", rd_b_n, 32'h1234);
    chk("r7_port_c", rd_c_b, 32'h1234);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      WE_N     = ($urandom_range(1) == 0);
      PC_LD_N  = ($urandom_range(9) != 0);
      PC_INC_N = ($urandom_range(2) != 0);
      WA   = 4'($urandom_range(15));
      WD   = $urandom;
      PC_D = $urandom;
      RA_A = 4'($urandom_range(15));
      RA_B = 4'($urandom_range(15));
      RA_C = 4'($urandom_range(15));
      step();
    end

    // Clear between edges with active enables: immediate, and nothing lands while held.
    idle();
    RA_A = 4'd3; RA_B = 4'd15; RA_C = 4'd4;
    WE_N = 1'b0; WA = 4'd4; WD = 32'hA5A5A5A5; PC_INC_N = 1'b0; PC_LD_N = 1'b0;
    PC_D = 32'h40;
    #2 CLR = 1'b0;
    #1;
    chk("clr_async_pc", pc_q_b, 32'h0);
    chk("clr_async_r3", rd_a_n, 32'h0);
    chk("clr_async_pc_read", rd_b_b, 32'h8);
    step(); step();
    chk("clr_held_pc", pc_q_n, 32'h0);
    chk("clr_held_r4", rd_c_n, 32'h0);
    idle();
    CLR = 1'b1;
    step();
    chk("clr_release_r4", rd_c_b, 32'h0);
    chk("clr_release_pc", pc_q_b, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_reg_file.md
Name: arm_reg_file

Overview:
- Parametrised ARM-style register bank built from the team's single-register style, generalised to NREGS entries.
- Three asynchronous read ports, one synchronous write port, and a dedicated program-counter register (highest index) with its own load and auto-increment path.
- Sits between decode and the ALU/shifter in the datapath. Supplies Rn/Rm/Rs operands and the fetch address.

Parameters:
- WIDTH, 32, data width of every register.
- NREGS, 16, number of registers; index NREGS-1 is the PC.
- AW, 4, address width; must satisfy 2**AW >= NREGS.
- PC_INC, 4, amount added to the PC on an increment.
- PC_RD_OFS, 8, offset added when the PC is read through a read port (pipeline prefetch view).
- BYPASS, 1, when 1 the read ports forward same-cycle write data.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- CLR  in  1  asynchronous active-low reset.
- WE_N  in  1  active-low write enable for the write port.
- WA  in  AW  write address.
- WD  in  WIDTH  write data.
- RA_A, RA_B, RA_C  in  AW each  read addresses.
- RD_A, RD_B, RD_C  out  WIDTH each  read data, combinational.
- PC_LD_N  in  1  active-low PC load (branch).
- PC_D  in  WIDTH  PC load value.
- PC_INC_N  in  1  active-low PC increment.
- PC_Q  out  WIDTH  current PC, unoffset, registered.

Behaviour:
- Reset: CLR low clears all NREGS registers to 0 immediately, regardless of CLK and enables. PC_Q = 0. RD_x reflect the cleared state (PC reads give PC_RD_OFS).
- CLR has absolute priority. While CLR is low, no write, load or increment takes effect. The first update happens on the first rising CLK with CLR high.
- General write: on a rising CLK with WE_N=0 and WA < NREGS-1, reg[WA] <= WD. WA >= NREGS (unused codes) is ignored with no state change.
- PC update priority per edge, highest first:
  1. WE_N=0 and WA=NREGS-1: PC <= WD.
  2. PC_LD_N=0: PC <= PC_D.
  3. PC_INC_N=0: PC <= PC + PC_INC, modulo 2**WIDTH (0xFFFFFFFC + 4 wraps to 0).
  4. Otherwise PC holds.
- A general-register write in the same cycle as a PC load or increment: both take effect.
- Reads are combinational:
  - RD_x = reg[RA_x] for RA_x < NREGS-1.
  - RA_x = NREGS-1 returns PC + PC_RD_OFS, modulo 2**WIDTH.
  - RA_x >= NREGS returns 0.
- Bypass with BYPASS=1: if WE_N=0, WA=RA_x and WA < NREGS-1, RD_x = WD in the same cycle.
  - PC reads are never bypassed; they always show the registered PC plus offset.
- Bypass with BYPASS=0: reads show the pre-edge value; the new value is visible after the edge.
- All three read ports are independent and may address the same register.
- Latency: write data appears in storage one edge after WE_N is sampled low.
- No X propagation: every register has a defined value from reset onward.

Test Plan:
- CLR low for 2 cycles after arbitrary writes -> all RD_x = 0 except PC reads = 0x8; PC_Q = 0. Assert CLR mid-cycle between edges -> clear is immediate, not edge-aligned.
- WE_N=0, WA=3, WD=0xDEADBEEF, RA_A=3, BYPASS=1 -> RD_A=0xDEADBEEF in the same cycle and after the edge. BYPASS=0 -> RD_A shows old value until the edge.
- PC_INC_N=0 for 3 edges from reset -> PC_Q 0x4, 0x8, 0xC. RA_B=15 -> RD_B=0x14. Load PC_D=0xFFFFFFFC, then increment -> PC_Q=0x0.
- Same edge: PC_LD_N=0 with PC_D=0x100, PC_INC_N=0, WE_N=0 with WA=15 and WD=0x200 -> PC_Q=0x200. Repeat with WE_N=1 -> PC_Q=0x100.
- Same edge: WE_N=0, WA=5, WD=0x55, and PC_INC_N=0 -> reg5=0x55 and PC advanced by 4.
- RA_A=RA_B=RA_C=7 after writing 0x1234 to R7 -> all three ports read 0x1234. Write with WE_N=1 -> R7 unchanged.
